// File: rtl/axil_cmd_sequencer.sv
// Pops {op, addr, data} commands from a native FIFO, runs one AXI4-Lite write or read
// per command and pushes {op, resp, data} into a native response FIFO.
module axil_cmd_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                                           ACLK,
    input  logic                                           ARESETN,
    input  logic                                           enable,
    input  logic                                           cmd_empty,
    output logic                                           cmd_rd,
    input  logic [C_M_AXI_ADDR_WIDTH+C_M_AXI_DATA_WIDTH:0] cmd_data,
    input  logic                                           rsp_full,
    output logic                                           rsp_wr,
    output logic [C_M_AXI_DATA_WIDTH+2:0]                  rsp_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                  M_AXI_AWADDR,
    output logic [2:0]                                     M_AXI_AWPROT,
    output logic                                           M_AXI_AWVALID,
    input  logic                                           M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]                  M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]                M_AXI_WSTRB,
    output logic                                           M_AXI_WVALID,
    input  logic                                           M_AXI_WREADY,
    input  logic [1:0]                                     M_AXI_BRESP,
    input  logic                                           M_AXI_BVALID,
    output logic                                           M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                  M_AXI_ARADDR,
    output logic [2:0]                                     M_AXI_ARPROT,
    output logic                                           M_AXI_ARVALID,
    input  logic                                           M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]                  M_AXI_RDATA,
    input  logic [1:0]                                     M_AXI_RRESP,
    input  logic                                           M_AXI_RVALID,
    output logic                                           M_AXI_RREADY,
    output logic                                           busy,
    output logic [15:0]                                    err_cnt,
    output logic                                           timeout
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, WADDR, WRESP, RADDR, RDATA, PUSH
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [15:0]     wait_cnt;
    logic            aw_done;
    logic            w_done;
    logic            waiting;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = data_q;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign busy         = (state != IDLE);

    // A write channel is finished once its VALID is low or is being accepted now.
    assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;
    assign waiting = (state == WADDR) || (state == WRESP) ||
                     (state == RADDR) || (state == RDATA);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            wait_cnt      <= '0;
            cmd_rd        <= 1'b0;
            rsp_wr        <= 1'b0;
            rsp_data      <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            err_cnt       <= '0;
            timeout       <= 1'b0;
        end else begin
            cmd_rd <= 1'b0;
            rsp_wr <= 1'b0;
            // Counter saturates at the limit; every state change below clears it.
            if (waiting) begin
                if (wait_cnt == TO_LAST) timeout <= 1'b1;
                if (wait_cnt != TO_MAX)  wait_cnt <= wait_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (enable && !cmd_empty) begin
                        state    <= FETCH;
                        cmd_rd   <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                FETCH: begin
                    state    <= LATCH;
                    wait_cnt <= '0;
                end
                LATCH: begin
                    addr_q   <= cmd_data[AW+DW-1:DW];
                    data_q   <= cmd_data[DW-1:0];
                    wait_cnt <= '0;
                    if (cmd_data[AW+DW]) begin
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        state         <= WADDR;
                    end else begin
                        M_AXI_ARVALID <= 1'b1;
                        state         <= RADDR;
                    end
                end
                WADDR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if (aw_done && w_done) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WRESP;
                        wait_cnt     <= '0;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_data     <= {1'b1, M_AXI_BRESP, data_q};
                        state        <= PUSH;
                        wait_cnt     <= '0;
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RDATA;
                        wait_cnt      <= '0;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_data     <= {1'b0, M_AXI_RRESP, M_AXI_RDATA};
                        state        <= PUSH;
                        wait_cnt     <= '0;
                    end
                end
                PUSH: begin
                    if (!rsp_full) begin
                        rsp_wr   <= 1'b1;
                        state    <= IDLE;
                        wait_cnt <= '0;
                        if ((rsp_data[DW+1:DW] != 2'b00) && (err_cnt != 16'hFFFF))
                            err_cnt <= err_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_sequencer.sv
// Directed bench for axil_cmd_sequencer: command/response FIFO models plus a small
// AXI4-Lite slave with controllable ready, response-enable and SLVERR behaviour.
module tb_axil_cmd_sequencer;

    localparam int TO = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        enable = 1'b0;
    logic        cmd_empty;
    logic        cmd_rd;
    logic [64:0] cmd_data = '0;
    logic        rsp_full = 1'b0;
    logic        rsp_wr;
    logic [34:0] rsp_data;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b1;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b1;
    logic        rvalid;
    logic        rready;
    logic        busy;
    logic [15:0] err_cnt;
    logic        timeout;

    logic        b_en = 1'b1;
    logic        slverr_en = 1'b0;

    logic [64:0] cmd_mem [16];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic [34:0] rsp_log [16];
    int          rsp_cyc [16];
    int          rsp_n = 0;
    int          cyc = 0;
    int          aw_hi = 0;
    int          w_hi = 0;
    int          b_hs_n = 0;
    int          cmd_rd_n = 0;

    logic [31:0] mem [16];
    logic        bvalid_q, rvalid_q, aw_seen, w_seen;
    logic [31:0] awaddr_q, wdata_q, rdata_q, last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;
    logic [1:0]  rresp_q;

    int checks = 0;
    int failures = 0;
    int t0, r0, c0, aw0, w0, b0;

    wire aw_hs = awvalid && awready;
    wire w_hs  = wvalid && wready;
    wire [31:0] waddr_eff = aw_hs ? awaddr : awaddr_q;
    wire [31:0] wdata_eff = w_hs ? wdata : wdata_q;

    assign cmd_empty = (rd_idx == wr_idx);
    assign bvalid    = bvalid_q && b_en;
    assign rvalid    = rvalid_q;

    axil_cmd_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
        .cmd_empty(cmd_empty), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
        .rsp_full(rsp_full), .rsp_wr(rsp_wr), .rsp_data(rsp_data),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(2'b00), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata_q), .M_AXI_RRESP(rresp_q), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready),
        .busy(busy), .err_cnt(err_cnt), .timeout(timeout)
    );

    always #5 ACLK = ~ACLK;

    // FIFO models and activity counters, all sampled on the DUT's clock edge.
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (awvalid) aw_hi <= aw_hi + 1;
        if (wvalid)  w_hi <= w_hi + 1;
        if (bvalid && bready) b_hs_n <= b_hs_n + 1;
        if (cmd_rd) begin
            cmd_data <= cmd_mem[rd_idx];
            rd_idx   <= rd_idx + 1;
            cmd_rd_n <= cmd_rd_n + 1;
        end
        if (rsp_wr) begin
            rsp_log[rsp_n] <= rsp_data;
            rsp_cyc[rsp_n] <= cyc;
            rsp_n          <= rsp_n + 1;
        end
    end

    // Slave: B follows completion of both AW and W; R follows AR with SLVERR on 0x8.
    always @(posedge ACLK) begin
        if (!ARESETN) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            aw_seen  <= 1'b0;
            w_seen   <= 1'b0;
        end else begin
            if (aw_hs) begin
                awaddr_q    <= awaddr;
                last_awaddr <= awaddr;
            end
            if (w_hs) begin
                wdata_q    <= wdata;
                last_wdata <= wdata;
                last_wstrb <= wstrb;
            end
            if (bvalid && bready) bvalid_q <= 1'b0;
            if ((aw_hs || aw_seen) && (w_hs || w_seen)) begin
                mem[waddr_eff[5:2]] <= wdata_eff;
                bvalid_q <= 1'b1;
                aw_seen  <= 1'b0;
                w_seen   <= 1'b0;
            end else begin
                if (aw_hs) aw_seen <= 1'b1;
                if (w_hs)  w_seen <= 1'b1;
            end
            if (arvalid && arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= mem[araddr[5:2]];
                rresp_q  <= (slverr_en && araddr == 32'h8) ? 2'b10 : 2'b00;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic op, input logic [31:0] addr, input logic [31:0] data);
        cmd_mem[wr_idx] = {op, addr, data};
        wr_idx = wr_idx + 1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitRsp(input int target, input string tag);
        for (int i = 0; i < 300 && rsp_n < target; i++) @(negedge ACLK);
        checkOutput(tag, 64'(rsp_n), 64'(target));
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        checkOutput("reset_ctrl", 64'({cmd_rd, rsp_wr, busy, timeout, awvalid, wvalid,
                                      bready, arvalid, rready}), 64'd0);
        checkOutput("reset_err_cnt", 64'(err_cnt), 64'd0);
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("reset_addr_data", 64'({awaddr, wdata}), 64'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Write 0x4 then read it back with an always-ready slave.
        applyStimulus(1'b1, 32'h4, 32'hA5A5_0001);
        applyStimulus(1'b0, 32'h4, 32'h0);
        t0 = cyc;
        enable = 1'b1;
        waitRsp(2, "wr_rd_rsp_count");
        checkOutput("wr_awaddr", 64'(last_awaddr), 64'h4);
        checkOutput("wr_wdata", 64'(last_wdata), 64'hA5A5_0001);
        checkOutput("wr_wstrb", 64'(last_wstrb), 64'hF);
        checkOutput("wr_rsp", 64'(rsp_log[0]), 64'({1'b1, 2'b00, 32'hA5A5_0001}));
        checkOutput("rd_rsp", 64'(rsp_log[1]), 64'({1'b0, 2'b00, 32'hA5A5_0001}));
        checkOutput("wr_latency", 64'(rsp_cyc[0] - t0), 64'd6);
        checkOutput("rd_latency", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'd6);

        // AWREADY three cycles late while WREADY is immediate.
        awready = 1'b0;
        aw0 = aw_hi; w0 = w_hi; b0 = b_hs_n;
        applyStimulus(1'b1, 32'h10, 32'h0000_1234);
        for (int i = 0; i < 20 && !awvalid; i++) @(negedge ACLK);
        checkOutput("split_awvalid_up", 64'(awvalid), 64'd1);
        repeat (3) @(negedge ACLK);
        awready = 1'b1;
        waitRsp(3, "split_rsp_count");
        checkOutput("split_aw_cycles", 64'(aw_hi - aw0), 64'd4);
        checkOutput("split_w_cycles", 64'(w_hi - w0), 64'd1);
        checkOutput("split_b_count", 64'(b_hs_n - b0), 64'd1);
        checkOutput("split_rsp", 64'(rsp_log[2]), 64'({1'b1, 2'b00, 32'h0000_1234}));

        // Response FIFO full for 10 cycles while parked in PUSH.
        rsp_full = 1'b1;
        applyStimulus(1'b0, 32'h4, 32'h0);
        repeat (6) @(negedge ACLK);
        applyStimulus(1'b0, 32'h10, 32'h0);
        r0 = rsp_n; c0 = cmd_rd_n;
        repeat (10) @(negedge ACLK);
        checkOutput("bp_no_rsp_wr", 64'(rsp_n - r0), 64'd0);
        checkOutput("bp_no_cmd_rd", 64'(cmd_rd_n - c0), 64'd0);
        checkOutput("bp_busy", 64'({busy, rsp_wr}), 64'b10);
        rsp_full = 1'b0;
        @(negedge ACLK);
        checkOutput("bp_rsp_wr_pulse", 64'(rsp_wr), 64'd1);
        @(negedge ACLK);
        checkOutput("bp_rsp_wr_single", 64'(rsp_wr), 64'd0);
        waitRsp(5, "bp_rsp_count");
        checkOutput("bp_rsp", 64'(rsp_log[3]), 64'({1'b0, 2'b00, 32'hA5A5_0001}));
        checkOutput("bp_next_rsp", 64'(rsp_log[4]), 64'({1'b0, 2'b00, 32'h0000_1234}));

        // SLVERR on read of 0x8, then counter saturation from a forced near-full value.
        applyStimulus(1'b1, 32'h8, 32'hDEAD_BEEF);
        waitRsp(6, "err_wr_count");
        slverr_en = 1'b1;
        applyStimulus(1'b0, 32'h8, 32'h0);
        waitRsp(7, "err_rd_count");
        checkOutput("err_rsp", 64'(rsp_log[6]), 64'({1'b0, 2'b10, 32'hDEAD_BEEF}));
        checkOutput("err_cnt_one", 64'(err_cnt), 64'd1);
        force dut.err_cnt = 16'hFFFE;
        @(negedge ACLK);
        release dut.err_cnt;
        @(negedge ACLK);
        checkOutput("err_cnt_forced", 64'(err_cnt), 64'hFFFE);
        applyStimulus(1'b0, 32'h8, 32'h0);
        waitRsp(8, "err_rd2_count");
        checkOutput("err_cnt_max", 64'(err_cnt), 64'hFFFF);
        applyStimulus(1'b0, 32'h8, 32'h0);
        waitRsp(9, "err_rd3_count");
        checkOutput("err_cnt_saturate", 64'(err_cnt), 64'hFFFF);
        slverr_en = 1'b0;

        // ARREADY low for TO+5 cycles.
        arready = 1'b0;
        applyStimulus(1'b0, 32'h4, 32'h0);
        for (int i = 0; i < 20 && !arvalid; i++) @(negedge ACLK);
        checkOutput("to_arvalid_up", 64'(arvalid), 64'd1);
        repeat (TO - 1) @(negedge ACLK);
        checkOutput("to_not_yet", 64'(timeout), 64'd0);
        @(negedge ACLK);
        checkOutput("to_set_arvalid", 64'({timeout, arvalid}), 64'b11);
        repeat (4) @(negedge ACLK);
        arready = 1'b1;
        waitRsp(10, "to_rsp_count");
        checkOutput("to_rsp", 64'(rsp_log[9]), 64'({1'b0, 2'b00, 32'hA5A5_0001}));
        checkOutput("to_sticky", 64'(timeout), 64'd1);

        // Reset asserted while the write waits for B.
        b_en = 1'b0;
        applyStimulus(1'b1, 32'h14, 32'h0000_0055);
        for (int i = 0; i < 20 && !bready; i++) @(negedge ACLK);
        checkOutput("rst_in_wresp", 64'(bready), 64'd1);
        ARESETN = 1'b0;
        @(negedge ACLK);
        checkOutput("rst_ctrl", 64'({cmd_rd, rsp_wr, busy, timeout, awvalid, wvalid,
                                    bready, arvalid, rready}), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("rst_addr_data", 64'({awaddr, wdata}), 64'd0);
        ARESETN = 1'b1;
        b_en = 1'b1;
        @(negedge ACLK);
        checkOutput("rst_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
